// File: rtl/mastermind_pkg.sv
// Shared types and constants for the Mastermind round controller.
package mastermind_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GUESS,
    EXACT,
    PARTIAL,
    WIN,
    LOSE
  } state_e;

  localparam int DEF_NUM_DIGITS  = 4;
  localparam int DEF_DIGIT_W     = 2;
  localparam int DEF_MAX_GUESSES = 8;

  // Width of the exact/partial/histogram counters (up to 4 matches).
  localparam int CNT_W = 3;

  // Fibonacci feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/mastermind_if.sv
// Button, guess and score/status bundle between the game controller and the board logic.
interface mastermind_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 2
) ();
  logic                          start_n;
  logic                          submit_n;
  logic                          use_fixed;
  logic [NUM_DIGITS*DIGIT_W-1:0] fixed_secret;
  logic [NUM_DIGITS*DIGIT_W-1:0] guess;
  logic [2:0]                    exact;
  logic [2:0]                    partial;
  logic                          score_valid;
  logic [3:0]                    guess_count;
  logic                          busy;
  logic                          win;
  logic                          lose;
  logic [NUM_DIGITS*DIGIT_W-1:0] secret;

  modport master (
    output start_n, submit_n, use_fixed, fixed_secret, guess,
    input  exact, partial, score_valid, guess_count, busy, win, lose, secret
  );

  modport slave (
    input  start_n, submit_n, use_fixed, fixed_secret, guess,
    output exact, partial, score_valid, guess_count, busy, win, lose, secret
  );
endinterface

// File: rtl/mastermind_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the random secret source.
module lfsr16
  import mastermind_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= SEED;
    else       q <= {q[14:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/mastermind_sequencer.sv
// Mastermind round controller: secret load, guess capture, two-pass scoring and win/lose tracking.
module mastermind_sequencer
  import mastermind_pkg::*;
#(
  parameter int          NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int          DIGIT_W     = DEF_DIGIT_W,
  parameter int          MAX_GUESSES = DEF_MAX_GUESSES,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic         clk,
  input logic         reset,
  mastermind_if.slave bus
);

  localparam int CODE_W   = NUM_DIGITS * DIGIT_W;
  localparam int NUM_COLS = 1 << DIGIT_W;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  state_e             state_q, state_d;
  logic               start_prev, submit_prev;
  logic               start_press, submit_press;
  logic [15:0]        lfsr_q;
  logic [CODE_W-1:0]  secret_q, guess_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DIGIT_W-1:0] col_q;
  logic [CNT_W-1:0]   hist_s_q [NUM_COLS];
  logic [CNT_W-1:0]   hist_g_q [NUM_COLS];
  logic [CNT_W-1:0]   exact_acc_q, partial_acc_q;
  logic [CNT_W-1:0]   exact_q, partial_q;
  logic               score_valid_q;
  logic [3:0]         guess_count_q;

  logic [DIGIT_W-1:0] s_dig, g_dig;
  logic [CNT_W-1:0]   partial_fin;
  logic [3:0]         guess_count_inc;
  logic               last_digit, last_col;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .q    (lfsr_q)
  );

  generate
    if (CODE_W < 16) begin : g_lfsr_hi
      logic unused_lfsr_hi;
      assign unused_lfsr_hi = ^lfsr_q[15:CODE_W];
    end
  endgenerate

  // Button capture: one register each, press is a 1->0 transition
  always_ff @(posedge clk) begin
    if (reset) begin
      start_prev  <= 1'b1;
      submit_prev <= 1'b1;
    end else begin
      start_prev  <= bus.start_n;
      submit_prev <= bus.submit_n;
    end
  end

  assign start_press  = start_prev & ~bus.start_n;
  assign submit_press = submit_prev & ~bus.submit_n;

  always_comb begin
    s_dig           = secret_q[idx_q*DIGIT_W +: DIGIT_W];
    g_dig           = guess_q[idx_q*DIGIT_W +: DIGIT_W];
    partial_fin     = partial_acc_q + min_cnt(hist_s_q[col_q], hist_g_q[col_q]);
    guess_count_inc = guess_count_q + 4'd1;
    last_digit      = (idx_q == IDX_W'(NUM_DIGITS - 1));
    last_col        = (col_q == DIGIT_W'(NUM_COLS - 1));
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Start overrides everything, including a submit in the same cycle
  always_comb begin
    state_d = state_q;
    if (start_press) begin
      state_d = WAIT_GUESS;
    end else begin
      case (state_q)
        WAIT_GUESS: if (submit_press) state_d = EXACT;
        EXACT:      if (last_digit) state_d = PARTIAL;
        PARTIAL: begin
          if (last_col) begin
            if (exact_acc_q == CNT_W'(NUM_DIGITS))
              state_d = WIN;
            else if (guess_count_inc == 4'(MAX_GUESSES))
              state_d = LOSE;
            else
              state_d = WAIT_GUESS;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Control and visible score registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q         <= '0;
      col_q         <= '0;
      exact_q       <= '0;
      partial_q     <= '0;
      score_valid_q <= 1'b0;
      guess_count_q <= '0;
    end else begin
      score_valid_q <= 1'b0;
      if (start_press) begin
        guess_count_q <= '0;
        exact_q       <= '0;
        partial_q     <= '0;
      end else begin
        case (state_q)
          WAIT_GUESS: if (submit_press) idx_q <= '0;
          EXACT: begin
            idx_q <= last_digit ? '0 : idx_q + 1'b1;
            if (last_digit) col_q <= '0;
          end
          PARTIAL: begin
            col_q <= col_q + 1'b1;
            if (last_col) begin
              exact_q       <= exact_acc_q;
              partial_q     <= partial_fin;
              score_valid_q <= 1'b1;
              guess_count_q <= guess_count_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Scoring datapath: exact pass fills histograms of unmatched digits
  always_ff @(posedge clk) begin
    if (start_press)
      secret_q <= bus.use_fixed ? bus.fixed_secret : lfsr_q[CODE_W-1:0];
    if (!start_press && state_q == WAIT_GUESS && submit_press) begin
      guess_q       <= bus.guess;
      exact_acc_q   <= '0;
      partial_acc_q <= '0;
      for (int c = 0; c < NUM_COLS; c++) begin
        hist_s_q[c] <= '0;
        hist_g_q[c] <= '0;
      end
    end
    if (state_q == EXACT) begin
      if (s_dig == g_dig) begin
        exact_acc_q <= exact_acc_q + 1'b1;
      end else begin
        hist_s_q[s_dig] <= hist_s_q[s_dig] + 1'b1;
        hist_g_q[g_dig] <= hist_g_q[g_dig] + 1'b1;
      end
    end
    if (state_q == PARTIAL)
      partial_acc_q <= partial_fin;
  end

  assign bus.exact       = exact_q;
  assign bus.partial     = partial_q;
  assign bus.score_valid = score_valid_q;
  assign bus.guess_count = guess_count_q;
  assign bus.busy        = (state_q == EXACT) || (state_q == PARTIAL);
  assign bus.win         = (state_q == WIN);
  assign bus.lose        = (state_q == LOSE);
  assign bus.secret      = (state_q == LOSE) ? secret_q : '0;

endmodule

// File: tb/tb_mastermind_sequencer.sv
// Scoreboard bench for mastermind_sequencer: expected scores queued at submit, checked at score_valid.
module tb_mastermind_sequencer;

  localparam int ND = 4;
  localparam int DW = 2;

  typedef struct {
    int ex;
    int pa;
    int gc;
    bit win;
    bit lose;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   gc_m = 0;
  logic [7:0]  cur_secret = '0;
  logic [15:0] lm;
  exp_t sb[$];

  mastermind_if #(.NUM_DIGITS(ND), .DIGIT_W(DW)) mif ();

  mastermind_sequencer #(
    .NUM_DIGITS (ND),
    .DIGIT_W    (DW),
    .MAX_GUESSES(8),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (mif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    lm  <= reset ? 16'hACE1 : {lm[14:0], lm[15] ^ lm[13] ^ lm[12] ^ lm[10]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void score(input logic [7:0] s, input logic [7:0] g,
                                output int ex, output int pa);
    int cs[4];
    int cg[4];
    ex = 0;
    pa = 0;
    for (int c = 0; c < 4; c++) begin cs[c] = 0; cg[c] = 0; end
    for (int i = 0; i < ND; i++) begin
      if (s[i*2 +: 2] == g[i*2 +: 2]) ex++;
      cs[s[i*2 +: 2]]++;
      cg[g[i*2 +: 2]]++;
    end
    for (int c = 0; c < 4; c++) pa += (cs[c] < cg[c]) ? cs[c] : cg[c];
    pa -= ex;
  endfunction

  always @(negedge clk) begin
    if (!reset && mif.score_valid) begin
      if (sb.size() == 0) begin
        check("spurious_score_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("exact", mif.exact, e.ex);
        check("partial", mif.partial, e.pa);
        check("guess_count", mif.guess_count, e.gc);
        check("win", mif.win, e.win);
        check("lose", mif.lose, e.lose);
        check("latency", cyc - e.cyc, 9);
      end
    end
  end

  task automatic check_zero(input string t);
    check({t, "_exact"}, mif.exact, 0);
    check({t, "_partial"}, mif.partial, 0);
    check({t, "_sv"}, mif.score_valid, 0);
    check({t, "_gc"}, mif.guess_count, 0);
    check({t, "_busy"}, mif.busy, 0);
    check({t, "_win"}, mif.win, 0);
    check({t, "_lose"}, mif.lose, 0);
    check({t, "_secret"}, mif.secret, 0);
  endtask

  task automatic press_start(input bit uf, input logic [7:0] fs, output logic [7:0] lfsr_exp);
    @(posedge clk);
    #1;
    mif.use_fixed    = uf;
    mif.fixed_secret = fs;
    mif.start_n      = 1'b0;
    lfsr_exp   = lm[7:0];
    cur_secret = uf ? fs : lm[7:0];
    gc_m       = 0;
    @(posedge clk);
    #1 mif.start_n = 1'b1;
  endtask

  task automatic push_exp(input logic [7:0] g);
    exp_t e;
    int ex, pa;
    score(cur_secret, g, ex, pa);
    gc_m++;
    e.ex   = ex;
    e.pa   = pa;
    e.gc   = gc_m;
    e.win  = (ex == ND);
    e.lose = (ex != ND) && (gc_m == 8);
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  task automatic do_submit(input logic [7:0] g, input bit accept, input int hold);
    @(posedge clk);
    #1;
    mif.guess    = g;
    mif.submit_n = 1'b0;
    if (accept) push_exp(g);
    repeat (hold) @(posedge clk);
    #1;
    mif.submit_n = 1'b1;
    mif.guess    = ~g;
  endtask

  task automatic wait_score();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check("score_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lx;
    mif.start_n      = 1'b1;
    mif.submit_n     = 1'b1;
    mif.use_fixed    = 1'b1;
    mif.fixed_secret = '0;
    mif.guess        = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    // Winning guess
    press_start(1'b1, 8'hE4, lx);
    do_submit(8'hE4, 1'b1, 1);
    wait_score();
    check("t1_win", mif.win, 1);
    check("t1_busy", mif.busy, 0);
    check("t1_secret_hidden", mif.secret, 0);

    // All colours misplaced
    press_start(1'b1, 8'hE4, lx);
    do_submit(8'h1B, 1'b1, 1);
    wait_score();
    check("t2_partial", mif.partial, 4);
    check("t2_not_win", mif.win, 0);
    check("t2_not_lose", mif.lose, 0);

    // Repeated colours: secret 0,0,1,1 guess 1,1,0,2
    press_start(1'b1, 8'h50, lx);
    do_submit(8'h85, 1'b1, 1);
    wait_score();
    check("t3_exact", mif.exact, 0);
    check("t3_partial", mif.partial, 3);

    // Press while busy, then a long hold
    press_start(1'b1, 8'hE4, lx);
    do_submit(8'h00, 1'b1, 1);
    @(posedge clk);
    #1 check("t4_busy", mif.busy, 1);
    do_submit(8'hE4, 1'b0, 1);
    wait_score();
    check("t4_gc_after_busy_press", mif.guess_count, 1);
    do_submit(8'h1B, 1'b1, 20);
    wait_score();
    check("t4_gc_after_hold", mif.guess_count, 2);

    // Simultaneous start and submit at guess_count 5
    press_start(1'b1, 8'hE4, lx);
    for (int k = 0; k < 5; k++) begin
      do_submit(8'h00, 1'b1, 1);
      wait_score();
    end
    check("t5_gc5", mif.guess_count, 5);
    @(posedge clk);
    #1;
    mif.start_n  = 1'b0;
    mif.submit_n = 1'b0;
    gc_m = 0;
    @(posedge clk);
    #1;
    mif.start_n  = 1'b1;
    mif.submit_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("t5_gc_cleared", mif.guess_count, 0);
    check("t5_exact_cleared", mif.exact, 0);
    check("t5_busy", mif.busy, 0);
    do_submit(8'hE4, 1'b1, 1);
    wait_score();

    // Lose after eight guesses
    press_start(1'b1, 8'hE4, lx);
    for (int k = 0; k < 8; k++) begin
      do_submit(8'h00, 1'b1, 1);
      wait_score();
    end
    check("t6_lose", mif.lose, 1);
    check("t6_reveal", mif.secret, 8'hE4);
    do_submit(8'hE4, 1'b0, 1);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("t6_gc_held", mif.guess_count, 8);
    check("t6_still_lose", mif.lose, 1);
    check("t6_exact_kept", mif.exact, 1);

    // Reset during PARTIAL
    press_start(1'b1, 8'hE4, lx);
    do_submit(8'hE4, 1'b1, 1);
    repeat (5) @(posedge clk);
    #1;
    check("t7_busy", mif.busy, 1);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check_zero("mid_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("t7_no_score", mif.guess_count, 0);

    // LFSR secret revealed via forced loss
    repeat (100) @(posedge clk);
    press_start(1'b0, 8'h00, lx);
    for (int k = 0; k < 8; k++) begin
      do_submit(~lx, 1'b1, 1);
      wait_score();
    end
    check("t8_lose", mif.lose, 1);
    check("t8_lfsr_secret", mif.secret, lx);

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
